// File: rtl/pll_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pll_ctrl_pkg
// Contents : FSM state encoding and default timing constants for the
//            PLL clock-select controller.
// Revision : 1.0 - initial release
// ============================================================================
package pll_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_PRST   = 3'd0,
      ST_WLOCK  = 3'd1,
      ST_IDLE   = 3'd2,
      ST_DEBNC  = 3'd3,
      ST_SWITCH = 3'd4,
      ST_ERR    = 3'd5
   } state_e;

   localparam int DEF_DEBOUNCE_CYCLES = 16;
   localparam int DEF_RST_CYCLES      = 8;
   localparam int DEF_LOCK_TIMEOUT    = 1024;
   localparam int DEF_SETTLE_CYCLES   = 4;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module   : sync_2ff
// Contents : Parameterized two-flop synchronizer for asynchronous inputs.
// Revision : 1.0 - initial release
// ============================================================================
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/pll_clk_sel_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pll_clk_sel_ctrl
// Contents : PLL reset/lock sequencer with debounced glitch-free clock select.
//            Define LOCK_LOSS_RECOVERY_EN to re-run the PLL reset on lock loss
//            and expose lock_loss_cnt.
// Revision : 1.0 - initial release
// ============================================================================
module pll_clk_sel_ctrl
   import pll_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int RST_CYCLES      = DEF_RST_CYCLES,
   parameter int LOCK_TIMEOUT    = DEF_LOCK_TIMEOUT,
   parameter int SETTLE_CYCLES   = DEF_SETTLE_CYCLES
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] sel_in,
   input  logic       pll_locked,
   output logic       pll_rst,
   output logic [1:0] clk_sel,
   output logic       busy,
   output logic       error
`ifdef LOCK_LOSS_RECOVERY_EN
   ,
   output logic [7:0] lock_loss_cnt
`endif
);

   // One shared phase counter, wide enough for the longest limit.
   localparam int CNT_MAX = max2(max2(DEBOUNCE_CYCLES, RST_CYCLES),
                                 max2(LOCK_TIMEOUT, SETTLE_CYCLES));
   localparam int CNT_W   = $clog2(CNT_MAX) + 1;

   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] DEBNC_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

   logic [1:0]       sel_s;
   logic             lock_s;
   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       cand_q, cand_d;
   logic [1:0]       clk_sel_q, clk_sel_d;
   logic             error_q, error_d;
   logic             lock_lost;

   sync_2ff #(.WIDTH(2)) u_sync_sel (
      .clk (clk),
      .rst (rst),
      .d_i (sel_in),
      .q_o (sel_s)
   );

   sync_2ff #(.WIDTH(1)) u_sync_lock (
      .clk (clk),
      .rst (rst),
      .d_i (pll_locked),
      .q_o (lock_s)
   );

   assign lock_lost = !lock_s && (state_q inside {ST_IDLE, ST_DEBNC, ST_SWITCH});

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      cand_d    = cand_q;
      clk_sel_d = clk_sel_q;
      error_d   = error_q;
      case (state_q)
         ST_PRST: begin
            if (cnt_q == RST_LAST) begin
               state_d = ST_WLOCK;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         ST_WLOCK: begin
            if (lock_s) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == LOCK_LAST) begin
               state_d = ST_ERR;
               cnt_d   = '0;
               error_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         ST_ERR: begin
            state_d = ST_PRST;
            cnt_d   = '0;
         end
         ST_IDLE: begin
            if (sel_s != clk_sel_q) begin
               state_d = ST_DEBNC;
               cand_d  = sel_s;
               cnt_d   = '0;
            end
         end
         ST_DEBNC: begin
            if (sel_s == clk_sel_q) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (sel_s != cand_q) begin
               cand_d = sel_s;
               cnt_d  = '0;
            end else if (cnt_q == DEBNC_LAST) begin
               // Both mux select bits move together in this one register update.
               state_d   = ST_SWITCH;
               clk_sel_d = cand_q;
               cnt_d     = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         ST_SWITCH: begin
            if (cnt_q == SETTLE_LAST) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = ST_PRST;
            cnt_d   = '0;
         end
      endcase

      // Lock loss overrides whatever the selector path decided this cycle.
      if (lock_lost) begin
         cand_d    = cand_q;
         clk_sel_d = clk_sel_q;
`ifdef LOCK_LOSS_RECOVERY_EN
         state_d   = ST_PRST;
         cnt_d     = '0;
`else
         state_d   = state_q;
         cnt_d     = cnt_q;
         error_d   = 1'b1;
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_PRST;
         cnt_q     <= '0;
         cand_q    <= 2'b00;
         clk_sel_q <= 2'b00;
         error_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         cand_q    <= cand_d;
         clk_sel_q <= clk_sel_d;
         error_q   <= error_d;
      end
   end

`ifdef LOCK_LOSS_RECOVERY_EN
   logic [7:0] loss_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         loss_cnt_q <= 8'd0;
      end else if (lock_lost && (loss_cnt_q != 8'hFF)) begin
         loss_cnt_q <= loss_cnt_q + 8'd1;
      end
   end

   assign lock_loss_cnt = loss_cnt_q;
`endif

   assign pll_rst = (state_q == ST_PRST);
   assign busy    = (state_q != ST_IDLE);
   assign clk_sel = clk_sel_q;
   assign error   = error_q;

endmodule
`default_nettype wire

// File: tb/tb_pll_clk_sel_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pll_clk_sel_ctrl
// Contents : Directed table-driven bench for pll_clk_sel_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pll_clk_sel_ctrl;

   logic       clk;
   logic       rst;
   logic [1:0] sel_in;
   logic       pll_locked;
   logic       pll_rst;
   logic [1:0] clk_sel;
   logic       busy;
   logic       error;
`ifdef LOCK_LOSS_RECOVERY_EN
   logic [7:0] lock_loss_cnt;
`endif

   int n_checks;
   int n_fail;

   typedef struct {
      logic       rst;
      logic [1:0] sel;
      logic       lock;
      int         ncyc;
      logic       e_prst;
      logic [1:0] e_sel;
      logic       e_busy;
      logic       e_err;
   } vec_t;

   vec_t vecs[$];

   pll_clk_sel_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .sel_in     (sel_in),
      .pll_locked (pll_locked),
      .pll_rst    (pll_rst),
      .clk_sel    (clk_sel),
      .busy       (busy),
      .error      (error)
`ifdef LOCK_LOSS_RECOVERY_EN
      ,
      .lock_loss_cnt (lock_loss_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   task automatic add(input logic r, input logic [1:0] s, input logic l, input int n,
                      input logic ep, input logic [1:0] es, input logic eb, input logic ee);
      vec_t v;
      v.rst = r; v.sel = s; v.lock = l; v.ncyc = n;
      v.e_prst = ep; v.e_sel = es; v.e_busy = eb; v.e_err = ee;
      vecs.push_back(v);
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      n_checks   = 0;
      n_fail     = 0;
      rst        = 1'b1;
      sel_in     = 2'b00;
      pll_locked = 1'b0;

      // Cycle counts are posedges after each row's inputs are applied (at a negedge).
      //   rst sel lock n    pll_rst clk_sel busy error
      add(1, 2'b00, 0, 3,   1, 2'b00, 1, 0);   // held in reset
      add(0, 2'b00, 0, 7,   1, 2'b00, 1, 0);   // PRST cycle 7
      add(0, 2'b00, 0, 1,   0, 2'b00, 1, 0);   // WLOCK after 8 cycles
      add(0, 2'b00, 0, 42,  0, 2'b00, 1, 0);   // cycle 50, still waiting
      add(0, 2'b00, 1, 2,   0, 2'b00, 1, 0);   // lock in synchronizer
      add(0, 2'b00, 1, 1,   0, 2'b00, 0, 0);   // IDLE 3 cycles after lock
      add(0, 2'b11, 1, 4,   0, 2'b00, 1, 0);   // glitch 11 -> DEBNC
      add(0, 2'b00, 1, 2,   0, 2'b00, 1, 0);   // back to 00, not yet seen
      add(0, 2'b00, 1, 1,   0, 2'b00, 0, 0);   // abandoned, IDLE
      add(0, 2'b00, 1, 20,  0, 2'b00, 0, 0);   // no switch happened
      add(0, 2'b01, 1, 10,  0, 2'b00, 1, 0);   // candidate 01
      add(0, 2'b11, 1, 18,  0, 2'b00, 1, 0);   // relatched 11, timer restarted
      add(0, 2'b11, 1, 1,   0, 2'b11, 1, 0);   // switch to 11
      add(0, 2'b11, 1, 3,   0, 2'b11, 1, 0);   // settling
      add(0, 2'b11, 1, 1,   0, 2'b11, 0, 0);   // settle done
      add(0, 2'b10, 1, 3,   0, 2'b11, 1, 0);   // sel 10 seen
      add(0, 2'b10, 1, 15,  0, 2'b11, 1, 0);   // debouncing
      add(0, 2'b10, 1, 1,   0, 2'b10, 1, 0);   // switch 2+1+16 cycles later
      add(0, 2'b10, 1, 3,   0, 2'b10, 1, 0);
      add(0, 2'b10, 1, 1,   0, 2'b10, 0, 0);   // busy for 4 settle cycles
      add(0, 2'b10, 0, 2,   0, 2'b10, 0, 0);   // lock dropped, not yet seen
`ifdef LOCK_LOSS_RECOVERY_EN
      add(0, 2'b10, 0, 1,   1, 2'b10, 1, 0);   // recovery: PLL reset
      add(0, 2'b10, 0, 2,   1, 2'b10, 1, 0);
      add(0, 2'b10, 1, 10,  0, 2'b10, 0, 0);   // relocked, IDLE again
`else
      add(0, 2'b10, 0, 1,   0, 2'b10, 0, 1);   // error, stays IDLE
      add(0, 2'b10, 0, 2,   0, 2'b10, 0, 1);
      add(0, 2'b10, 1, 10,  0, 2'b10, 0, 1);   // error sticky
`endif

      @(negedge clk);
      foreach (vecs[i]) begin
         rst        = vecs[i].rst;
         sel_in     = vecs[i].sel;
         pll_locked = vecs[i].lock;
         cycles(vecs[i].ncyc);
         chk($sformatf("vec%0d_pll_rst", i), {7'd0, pll_rst}, {7'd0, vecs[i].e_prst});
         chk($sformatf("vec%0d_clk_sel", i), {6'd0, clk_sel}, {6'd0, vecs[i].e_sel});
         chk($sformatf("vec%0d_busy", i),    {7'd0, busy},    {7'd0, vecs[i].e_busy});
         chk($sformatf("vec%0d_error", i),   {7'd0, error},   {7'd0, vecs[i].e_err});
      end
`ifdef LOCK_LOSS_RECOVERY_EN
      chk("lock_loss_cnt_one", lock_loss_cnt, 8'd1);
`endif

      // Asynchronous reset in the middle of SWITCH.
      sel_in = 2'b01;
      cycles(20);
      chk("midswitch_clk_sel", {6'd0, clk_sel}, 8'h01);
      chk("midswitch_busy",    {7'd0, busy},    8'h01);
      #1 rst = 1'b1;
      #1;
      chk("async_rst_clk_sel", {6'd0, clk_sel}, 8'h00);
      chk("async_rst_pll_rst", {7'd0, pll_rst}, 8'h01);
      chk("async_rst_busy",    {7'd0, busy},    8'h01);
      chk("async_rst_error",   {7'd0, error},   8'h00);
`ifdef LOCK_LOSS_RECOVERY_EN
      chk("async_rst_loss_cnt", lock_loss_cnt, 8'd0);
`endif

      // Lock never arrives: timeout, ERR, automatic retry.
      sel_in     = 2'b00;
      pll_locked = 1'b0;
      cycles(3);
      rst = 1'b0;
      cycles(1031);
      chk("timeout_err_before", {7'd0, error},   8'h00);
      cycles(1);
      chk("timeout_err_set",    {7'd0, error},   8'h01);
      chk("timeout_in_err",     {7'd0, pll_rst}, 8'h00);
      cycles(1);
      chk("retry_prst_first",   {7'd0, pll_rst}, 8'h01);
      cycles(7);
      chk("retry_prst_last",    {7'd0, pll_rst}, 8'h01);
      cycles(1);
      chk("retry_prst_end",     {7'd0, pll_rst}, 8'h00);
      chk("retry_err_sticky",   {7'd0, error},   8'h01);
      pll_locked = 1'b1;
      cycles(5);
      chk("retry_locked_idle",  {7'd0, busy},    8'h00);
      chk("retry_err_kept",     {7'd0, error},   8'h01);
      chk("retry_clk_sel",      {6'd0, clk_sel}, 8'h00);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pll_clk_sel_ctrl.md
PLL_CLK_SEL_CTRL -- requirements
Module: pll_clk_sel_ctrl

Interface
REQ-001 The block SHALL have one clock and one reset: reset is asynchronous and active-high, ports named clk and rst.
REQ-002 Parameter DEBOUNCE_CYCLES, default 16, SHALL set the number of cycles a new selector value must stay stable before it is accepted.
REQ-003 Parameter RST_CYCLES, default 8, SHALL set the pll_rst pulse length in cycles.
REQ-004 Parameter LOCK_TIMEOUT, default 1024, SHALL set the maximum number of cycles to wait for lock.
REQ-005 Parameter SETTLE_CYCLES, default 4, SHALL set the number of cycles busy is held after a selection change.
REQ-006 Port clk SHALL be an input, 1 bit: 100 MHz on-board clock.
REQ-007 Port rst SHALL be an input, 1 bit: asynchronous, active-high reset.
REQ-008 Port sel_in SHALL be an input, 2 bits: raw slide-switch selector, asynchronous to clk.
REQ-009 Port pll_locked SHALL be an input, 1 bit: PLL lock indicator, asynchronous to clk.
REQ-010 Port pll_rst SHALL be an output, 1 bit: reset to the PLL core.
REQ-011 Port clk_sel SHALL be an output, 2 bits: select to the clock-mux tree (bit0 drives the first-level muxes, bit1 the second level).
REQ-012 Port busy SHALL be an output, 1 bit: high while not in IDLE.
REQ-013 Port error SHALL be an output, 1 bit: sticky lock failure flag.

Function
REQ-014 sel_in and pll_locked SHALL each pass through a 2-flop synchronizer (sel_s, lock_s), giving 2 cycles of latency.
REQ-015 The FSM SHALL have exactly six states: PRST, WLOCK, IDLE, DEBNC, SWITCH, ERR.
REQ-016 PRST SHALL assert pll_rst for exactly RST_CYCLES cycles, then go to WLOCK.
REQ-017 WLOCK SHALL go to IDLE on lock_s=1; if lock_s stays 0 for LOCK_TIMEOUT cycles, WLOCK SHALL go to ERR.
REQ-018 ERR SHALL set error=1 and, on the next cycle, go to PRST (automatic retry).
REQ-019 IDLE, on sel_s != clk_sel, SHALL latch sel_s as the candidate, clear the counter and go to DEBNC.
REQ-020 DEBNC SHALL behave as follows: if sel_s equals clk_sel, return to IDLE; else if sel_s differs from the candidate, relatch the candidate and clear the counter; else, after DEBOUNCE_CYCLES stable cycles, go to SWITCH.
REQ-021 On SWITCH entry, clk_sel SHALL update to the candidate in a single registered step; both bits change in the same cycle.
REQ-022 SWITCH SHALL hold for SETTLE_CYCLES cycles, then go to IDLE; sel_s changes during SWITCH SHALL be ignored until IDLE.
REQ-023 clk_sel SHALL be preserved across PRST and WLOCK and SHALL never change outside SWITCH entry.
REQ-024 lock_s falling in IDLE, DEBNC or SWITCH SHALL be a lock-loss event, handled per REQ-030 and REQ-031; lock loss SHALL take priority over a simultaneous selector change.
REQ-025 Every counter SHALL be sized to $clog2 of its limit plus 1 and SHALL never wrap.

Reset
REQ-026 During rst=1 the outputs SHALL be: pll_rst=1, clk_sel=2'b00, busy=1, error=0; the FSM SHALL be in PRST and all counters and synchronizers SHALL be 0.
REQ-027 After rst deassertion the block SHALL run a full PRST → WLOCK sequence.
REQ-028 rst asserted mid-operation, including mid-SWITCH, SHALL return immediately to the reset values.
REQ-029 error SHALL be cleared only by rst.

Configuration
REQ-030 With LOCK_LOSS_RECOVERY_EN defined, a lock-loss event SHALL send the FSM to PRST, increment output lock_loss_cnt[7:0] (saturating at 255, reset 0) and leave error unchanged.
REQ-031 Without LOCK_LOSS_RECOVERY_EN, a lock-loss event SHALL set error=1 and the FSM SHALL stay in its current state, the lock_loss_cnt port SHALL be absent, and no automatic PLL reset SHALL occur.

Structure
REQ-032 Package pll_ctrl_pkg SHALL hold the state enum typedef and the default parameter constants.
REQ-033 Sub-module sync_2ff (parameterized width) SHALL implement the synchronizers and be instantiated twice.

Verification
REQ-034 Release rst, then raise pll_locked at cycle 50 → pll_rst=1 for 8 cycles, busy falls 2–3 cycles after lock, clk_sel=00.
REQ-035 Hold pll_locked=0 → error=1 at 8+1024 cycles after release, pll_rst pulses again for 8 cycles.
REQ-036 In IDLE, set sel_in=10 → clk_sel=10 after 2+16 cycles, busy high 4 more cycles.
REQ-037 In IDLE, toggle sel_in 00→11→00 within 10 cycles → clk_sel stays 00, FSM returns to IDLE.
REQ-038 Drop pll_locked for 5 cycles in IDLE → with the macro: pll_rst pulse, lock_loss_cnt=1, error=0; without it: error=1, no pll_rst.
REQ-039 Assert rst during SWITCH → clk_sel=00, pll_rst=1 immediately.
